pipe_stall_ctrl: RTL and testbench

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 56 +++++
 rtl/pipe_wait_timer.sv | 40 ++++
 rtl/pipe_stall_ctrl.sv | 136 +++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline stall controller: FSM encodings,
// the default memory-wait limit, and the hazard / stall-control decode.
package pipe_ctrl_pkg;

    localparam int MAX_WAIT_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_en;
        logic fd_en;
        logic de_en;
        logic em_en;
        logic de_bubble;
        logic mw_bubble;
    } stall_ctl_t;

    // A load in EX whose destination feeds an ID-stage source cannot be forwarded in time.
    function automatic logic load_use(
        input logic       ewreg,
        input logic       em2reg,
        input logic [4:0] ern,
        input logic [4:0] drs,
        input logic [4:0] drt,
        input logic       use_rs,
        input logic       use_rt
    );
        logic rs_hit;
        logic rt_hit;
        rs_hit = use_rs && (ern == drs);
        rt_hit = use_rt && (ern == drt);
        return ewreg && em2reg && (ern != 5'd0) && (rs_hit || rt_hit);
    endfunction

    // Freeze holds every stage and drains a bubble into MEM/WB; a load-use
    // stall holds PC and IF/ID while ID/EX takes one NOP.
    function automatic stall_ctl_t stall_decode(input logic frz, input logic lu);
        stall_ctl_t c;
        if (frz) begin
            c = '{pc_en: 1'b0, fd_en: 1'b0, de_en: 1'b0, em_en: 1'b0,
                  de_bubble: 1'b0, mw_bubble: 1'b1};
        end else if (lu) begin
            c = '{pc_en: 1'b0, fd_en: 1'b0, de_en: 1'b1, em_en: 1'b1,
                  de_bubble: 1'b1, mw_bubble: 1'b0};
        end else begin
            c = '{pc_en: 1'b1, fd_en: 1'b1, de_en: 1'b1, em_en: 1'b1,
                  de_bubble: 1'b0, mw_bubble: 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/pipe_wait_timer.sv
// Memory-wait cycle counter: loads 1 on WAIT entry, counts each further WAIT
// cycle, and flags the cycle on which it has reached MAX_WAIT.
module pipe_wait_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic clock,
    input  logic resetn,
    input  logic load_i,
    input  logic inc_i,
    output logic tc_o
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Idle cycles clear the count so nothing carries into the next access.
    always_comb begin
        count_d = '0;
        if (load_i) begin
            count_d = CW'(1);
        end else if (inc_i) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == CW'(MAX_WAIT));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/freeze controller: load-use bubbles plus a memory-wait FSM
// with sticky timeout. Optional PIPE_STALL_PERF_EN adds lu_cnt / frz_cnt.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic [4:0]  ern,
    input  logic [4:0]  drs,
    input  logic [4:0]  drt,
    input  logic        use_rs,
    input  logic        use_rt,
    input  logic        mreq,
    input  logic        mack,
    output logic        pc_en,
    output logic        fd_en,
    output logic        de_en,
    output logic        em_en,
    output logic        de_bubble,
    output logic        mw_bubble,
    output logic        mem_err,
    output logic [1:0]  state
`ifdef PIPE_STALL_PERF_EN
    ,
    output logic [31:0] lu_cnt,
    output logic [31:0] frz_cnt
`endif
);

    state_e     state_q;
    logic       mem_err_q;
    logic       ack;
    logic       req_pend;
    logic       lu;
    logic       frz;
    logic       tmr_load;
    logic       tmr_inc;
    logic       tmr_tc;
    stall_ctl_t ctl;

    assign ack      = mreq & mack;
    assign req_pend = mreq & ~mack;
    assign lu       = load_use(ewreg, em2reg, ern, drs, drt, use_rs, use_rt);

    // The acknowledge cycle itself releases the freeze, matching a zero-wait hit.
    always_comb begin
        frz = 1'b0;
        case (state_q)
            ST_RUN:  frz = req_pend;
            ST_WAIT: frz = ~ack;
            ST_ERR:  frz = 1'b1;
            default: frz = 1'b0;
        endcase
    end

    assign ctl       = stall_decode(frz, lu);
    assign pc_en     = ctl.pc_en;
    assign fd_en     = ctl.fd_en;
    assign de_en     = ctl.de_en;
    assign em_en     = ctl.em_en;
    assign de_bubble = ctl.de_bubble;
    assign mw_bubble = ctl.mw_bubble;
    assign mem_err   = mem_err_q;
    assign state     = state_q;

    assign tmr_load = (state_q == ST_RUN) & req_pend;
    assign tmr_inc  = (state_q == ST_WAIT) & ~ack & ~tmr_tc;

    pipe_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clock  (clock),
        .resetn (resetn),
        .load_i (tmr_load),
        .inc_i  (tmr_inc),
        .tc_o   (tmr_tc)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_RUN;
            mem_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (req_pend) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (ack) begin
                        state_q <= ST_RUN;
                    end else if (tmr_tc) begin
                        state_q   <= ST_ERR;
                        mem_err_q <= 1'b1;
                    end
                end
                ST_ERR: begin
                    state_q   <= ST_ERR;
                    mem_err_q <= 1'b1;
                end
                default: begin
                    state_q   <= ST_RUN;
                    mem_err_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_STALL_PERF_EN
    logic [31:0] lu_cnt_q;
    logic [31:0] frz_cnt_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            lu_cnt_q  <= '0;
            frz_cnt_q <= '0;
        end else begin
            if (lu && !frz && (lu_cnt_q != 32'hFFFF_FFFF)) begin
                lu_cnt_q <= lu_cnt_q + 32'd1;
            end
            if (frz && (frz_cnt_q != 32'hFFFF_FFFF)) begin
                frz_cnt_q <= frz_cnt_q + 32'd1;
            end
        end
    end

    assign lu_cnt  = lu_cnt_q;
    assign frz_cnt = frz_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl with MAX_WAIT=4: directed hazard,
// wait, timeout and reset cases followed by protocol-respecting random traffic.
module tb_pipe_stall_ctrl;

    localparam int MW = 4;

    logic        clock = 1'b0;
    logic        resetn;
    logic        ewreg, em2reg, use_rs, use_rt, mreq, mack;
    logic [4:0]  ern, drs, drt;
    logic        pc_en, fd_en, de_en, em_en, de_bubble, mw_bubble, mem_err;
    logic [1:0]  state;
`ifdef PIPE_STALL_PERF_EN
    logic [31:0] lu_cnt, frz_cnt;
`endif

    pipe_stall_ctrl #(.MAX_WAIT(MW)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .ewreg     (ewreg),
        .em2reg    (em2reg),
        .ern       (ern),
        .drs       (drs),
        .drt       (drt),
        .use_rs    (use_rs),
        .use_rt    (use_rt),
        .mreq      (mreq),
        .mack      (mack),
        .pc_en     (pc_en),
        .fd_en     (fd_en),
        .de_en     (de_en),
        .em_en     (em_en),
        .de_bubble (de_bubble),
        .mw_bubble (mw_bubble),
        .mem_err   (mem_err),
        .state     (state)
`ifdef PIPE_STALL_PERF_EN
        ,
        .lu_cnt    (lu_cnt),
        .frz_cnt   (frz_cnt)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    int n_checks = 0;
    int n_errors = 0;
    logic [8:0] exp_q[$];

    // Reference model state.
    logic [1:0]  m_state;
    int          m_cnt;
    logic [31:0] m_lu, m_frz;

    // {pc_en, fd_en, de_en, em_en, de_bubble, mw_bubble, mem_err, state[1:0]}
    wire [8:0] dut_vec = {pc_en, fd_en, de_en, em_en, de_bubble, mw_bubble, mem_err, state};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] model_vec();
        logic hz, fz;
        logic [3:0] en;
        logic deb, mwb;
        hz = ewreg && em2reg && (ern != 5'd0) &&
             ((use_rs && ern == drs) || (use_rt && ern == drt));
        fz = (m_state == 2'd0 && mreq && !mack) ||
             (m_state == 2'd1 && !(mreq && mack)) ||
             (m_state == 2'd2);
        if (fz) begin
            en = 4'b0000; deb = 1'b0; mwb = 1'b1;
        end else if (hz) begin
            en = 4'b0011; deb = 1'b1; mwb = 1'b0;
        end else begin
            en = 4'b1111; deb = 1'b0; mwb = 1'b0;
        end
        return {en, deb, mwb, (m_state == 2'd2), m_state};
    endfunction

    task automatic model_reset();
        m_state = 2'd0;
        m_cnt   = 0;
        m_lu    = '0;
        m_frz   = '0;
    endtask

    task automatic model_advance(input logic [8:0] v);
        if (v[3]) m_frz++;
        else if (v[4]) m_lu++;
        case (m_state)
            2'd0: if (mreq && !mack) begin m_state = 2'd1; m_cnt = 1; end
            2'd1: begin
                if (mreq && mack) begin
                    m_state = 2'd0; m_cnt = 0;
                end else if (m_cnt == MW) begin
                    m_state = 2'd2; m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
            default: ;
        endcase
    endtask

    task automatic set_in(input logic ew, input logic em, input logic [4:0] e,
                          input logic [4:0] s, input logic [4:0] t,
                          input logic urs, input logic urt,
                          input logic mr, input logic ma);
        ewreg = ew; em2reg = em; ern = e; drs = s; drt = t;
        use_rs = urs; use_rt = urt; mreq = mr; mack = ma;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Entered at a negedge with inputs applied; leaves at the next negedge.
    task automatic cycle(input string tag, output logic [8:0] obs);
        logic [8:0] e;
        exp_q.push_back(model_vec());
        #1;
        e   = exp_q.pop_front();
        obs = dut_vec;
        check_eq(tag, dut_vec, e);
`ifdef PIPE_STALL_PERF_EN
        check_eq({tag, "_lu_cnt"}, lu_cnt, m_lu);
        check_eq({tag, "_frz_cnt"}, frz_cnt, m_frz);
`endif
        model_advance(e);
        @(negedge clock);
    endtask

    // Asynchronous reset: the effect must be visible before any clock edge.
    task automatic pulse_reset(input string tag);
        resetn = 1'b0;
        #1;
        check_eq({tag, "_state"}, state, 0);
        check_eq({tag, "_mem_err"}, mem_err, 0);
        model_reset();
        @(negedge clock);
        resetn = 1'b1;
    endtask

    initial begin
        logic [8:0] obs;
        int nfrz, ndeb;
        logic seen_wait, req_hold;
        string tag;

        resetn = 1'b0;
        idle();
        model_reset();
        #1;
        check_eq("rst_state", state, 0);
        check_eq("rst_mem_err", mem_err, 0);
        check_eq("rst_vec", dut_vec, model_vec());
        @(negedge clock);
        resetn = 1'b1;

        // Load-use on rs: one stall cycle then free flow.
        set_in(1, 1, 5, 5, 0, 1, 0, 0, 0);
        cycle("lu_rs", obs);
        check_eq("lu_rs_pc_en", obs[8], 0);
        check_eq("lu_rs_de_bubble", obs[4], 1);
        idle();
        cycle("lu_rs_next", obs);
        check_eq("lu_rs_next_en", obs[8:5], 4'b1111);

        // Destination r0 is never a hazard.
        set_in(1, 1, 0, 0, 0, 1, 0, 0, 0);
        cycle("lu_r0", obs);
        check_eq("lu_r0_pc_en", obs[8], 1);

        // Hazard via rt; rt match without use_rt is no hazard.
        set_in(1, 1, 7, 3, 7, 1, 1, 0, 0);
        cycle("lu_rt", obs);
        check_eq("lu_rt_de_bubble", obs[4], 1);
        set_in(1, 1, 7, 3, 7, 1, 0, 0, 0);
        cycle("lu_rt_unused", obs);
        check_eq("lu_rt_unused_pc_en", obs[8], 1);

        // Zero-wait access.
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
        cycle("zero_wait", obs);
        check_eq("zero_wait_mw_bubble", obs[3], 0);
        idle();
        cycle("zero_wait_after", obs);
        check_eq("zero_wait_state", obs[1:0], 0);

        // Stray mack without mreq is ignored.
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle("stray_mack", obs);
        check_eq("stray_mack_state", obs[1:0], 0);

        // Ack after 3 frozen cycles.
        nfrz = 0; seen_wait = 0;
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cycle("wait3", obs);
            if (obs[3] && obs[8:5] == 4'b0000) nfrz++;
            if (obs[1:0] == 2'd1) seen_wait = 1;
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
        cycle("wait3_ack", obs);
        check_eq("wait3_ack_en", obs[8:5], 4'b1111);
        idle();
        cycle("wait3_after", obs);
        check_eq("wait3_frozen_cycles", nfrz, 3);
        check_eq("wait3_seen_wait", seen_wait, 1);
        check_eq("wait3_back_run", obs[1:0], 0);

        // Ack on the terminal WAIT cycle wins over the timeout.
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < MW; i++) cycle("tc_ack_wait", obs);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
        cycle("tc_ack", obs);
        idle();
        cycle("tc_ack_after", obs);
        check_eq("tc_ack_state", obs[1:0], 0);
        check_eq("tc_ack_mem_err", obs[2], 0);

        // Timeout: RUN cycle + MW WAIT cycles, then ERR; late ack ignored.
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < MW + 1; i++) cycle("tmo_wait", obs);
        cycle("tmo_err", obs);
        check_eq("tmo_err_state", obs[1:0], 2);
        check_eq("tmo_err_mem_err", obs[2], 1);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
        cycle("tmo_late_ack", obs);
        idle();
        cycle("tmo_sticky", obs);
        check_eq("tmo_sticky_mem_err", obs[2], 1);
        check_eq("tmo_sticky_en", obs[8:5], 4'b0000);
        pulse_reset("tmo_reset");
        cycle("tmo_after_reset", obs);
        check_eq("tmo_after_reset_en", obs[8:5], 4'b1111);

        // Reset mid-WAIT abandons the access.
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle("rst_wait0", obs);
        cycle("rst_wait1", obs);
        pulse_reset("rst_mid_wait");
        idle();
        cycle("rst_mid_wait_after", obs);
        check_eq("rst_mid_wait_state", obs[1:0], 0);

        // Load-use coincident with a memory freeze.
        nfrz = 0; ndeb = 0;
        set_in(1, 1, 9, 9, 0, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cycle("lu_frz", obs);
            if (obs[3]) nfrz++;
            if (obs[4]) ndeb++;
        end
        set_in(1, 1, 9, 9, 0, 1, 0, 1, 1);
        cycle("lu_frz_ack", obs);
        if (obs[3]) nfrz++;
        if (obs[4]) ndeb++;
        idle();
        cycle("lu_frz_after", obs);
        if (obs[4]) ndeb++;
        check_eq("lu_frz_frozen", nfrz, 3);
        check_eq("lu_frz_bubbles", ndeb, 1);

        // Random traffic keeping mreq held until acknowledged.
        req_hold = 0;
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 1), $urandom_range(0, 1), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   $urandom_range(0, 1), $urandom_range(0, 1),
                   req_hold ? 1'b1 : ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 2) == 0));
            if ($urandom_range(0, 4) == 0 && !req_hold) mack = 1'b1;
            req_hold = mreq && !mack;
            tag = $sformatf("rnd%0d", i);
            cycle(tag, obs);
            if (m_state == 2'd2 && $urandom_range(0, 2) == 0) begin
                pulse_reset("rnd_reset");
                req_hold = 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
